// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state enum, opcodes, mux/ALU encodings.
// Build option CTRL_ADDI_EN adds the ADDI_EX/ADDI_WB states and addi decode.
package ctrl_pkg;

`ifdef CTRL_ADDI_EN
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMRD    = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWR    = 4'd6,
    ST_RTYPE_EX = 4'd7,
    ST_RTYPE_WB = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_ADDI_EX  = 4'd11,
    ST_ADDI_WB  = 4'd12
  } state_e;
`else
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMRD    = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWR    = 4'd6,
    ST_RTYPE_EX = 4'd7,
    ST_RTYPE_WB = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10
  } state_e;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_BROFF = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // One bundle of every Moore control line, so decode can default it to zero in one go.
  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       i_or_d;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational next-state and control-line decode for control_fsm.
// Build option CTRL_ADDI_EN enables the addi path; otherwise addi takes the illegal path.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output state_e     next_state,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       retire
);

  always_comb begin
    next_state = state;
    ctrl       = '0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      // IR load and PC increment only fire in the cycle the memory completes.
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRC_B_BROFF;
        ctrl.alu_op    = ALU_OP_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_RTYPE_EX;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      next_state = ST_ADDI_EX;
`endif
          default: begin
            next_state = ST_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        next_state     = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready) next_state = ST_MEMWB;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        next_state      = ST_FETCH;
        retire          = 1'b1;
      end
      // A store retires on the same edge its memory write completes.
      ST_MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) begin
          next_state = ST_FETCH;
          retire     = 1'b1;
        end
      end
      ST_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
        next_state     = ST_RTYPE_WB;
      end
      ST_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next_state     = ST_FETCH;
        retire         = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        next_state         = ST_FETCH;
        retire             = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        next_state     = ST_FETCH;
        retire         = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      ST_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        next_state     = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
        next_state     = ST_FETCH;
        retire         = 1'b1;
      end
`endif
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle MIPS-style control FSM: state, retired-instruction counter and illegal-opcode pulse.
// Build option CTRL_ADDI_EN enables addi support in the decoder.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  state_e      state_q;
  state_e      next_state;
  ctrl_t       ctrl;
  logic        decode_illegal;
  logic        retire;
  logic [31:0] count_q;

  ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state),
    .ctrl       (ctrl),
    .illegal    (decode_illegal),
    .retire     (retire)
  );

  // Reset wins over any in-flight memory access; the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= next_state;
      illegal_op <= decode_illegal;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_count   = count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed scenarios plus a random instruction stream
// checked cycle by cycle against a per-instruction control-word sequence model.
module tb_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        reg_dst, reg_write, mem_to_reg, mem_read, mem_write, ir_write;
  logic        i_or_d, pc_write, pc_write_cond, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        illegal_op;
  logic [31:0] instr_count;
  logic [3:0]  state;

  control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count),
    .state         (state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // control word: rd rw m2r mr mw irw iod pw pwc asa | asb[2] aop[2] psrc[2]
  function automatic logic [15:0] cw(input bit rd, rw, m2r, mr, mw, irw, iod, pw, pwc, asa,
                                     input logic [1:0] asb, aop, psrc);
    return {rd, rw, m2r, mr, mw, irw, iod, pw, pwc, asa, asb, aop, psrc};
  endfunction

  logic [15:0] w_idle, w_fetch_wait, w_fetch, w_decode, w_memadr, w_memrd, w_memwb;
  logic [15:0] w_memwr, w_rtype_ex, w_rtype_wb, w_branch, w_jump, w_addi_ex, w_addi_wb;

  initial begin
    w_idle       = cw(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    w_fetch_wait = cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    w_fetch      = cw(0,0,0,1,0,1,0,1,0,0, 2'b01, 2'b00, 2'b00);
    w_decode     = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
    w_memadr     = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    w_memrd      = cw(0,0,0,1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00);
    w_memwb      = cw(0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    w_memwr      = cw(0,0,0,0,1,0,1,0,0,0, 2'b00, 2'b00, 2'b00);
    w_rtype_ex   = cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
    w_rtype_wb   = cw(1,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    w_branch     = cw(0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b01, 2'b01);
    w_jump       = cw(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b10);
    w_addi_ex    = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    w_addi_wb    = cw(0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
  end

  logic [15:0] obs_cw;
  assign obs_cw = {reg_dst, reg_write, mem_to_reg, mem_read, mem_write, ir_write, i_or_d,
                   pc_write, pc_write_cond, alu_src_a, alu_src_b, alu_op, pc_source};

  // scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_count;
  logic        exp_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: inputs already driven, compare mid-cycle, then advance.
  task automatic step(input string tag, input logic [15:0] exp_cw);
    #1;
    check({tag, ".cw"},  32'(obs_cw), 32'(exp_cw));
    check({tag, ".ill"}, 32'(illegal_op), 32'(exp_ill));
    check({tag, ".cnt"}, instr_count, exp_count);
    @(posedge clk);
    #1;
    exp_ill = 1'b0;
  endtask

  function automatic logic rnd_ready(input bit tie);
    return tie ? 1'b1 : 1'(($urandom_range(0, 1)));
  endfunction

  // Reference model: the cycle sequence an instruction must produce, from fetch to retire.
  task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait,
                           input bit tie);
    for (int i = 0; i < fetch_wait; i++) begin
      opcode = 6'($urandom); mem_ready = 1'b0;
      step("fetch_wait", w_fetch_wait);
    end
    opcode = 6'($urandom); mem_ready = 1'b1;
    step("fetch", w_fetch);
    opcode = op; mem_ready = rnd_ready(tie);
    step("decode", w_decode);
    if (op == OP_LW || op == OP_SW) begin
      mem_ready = rnd_ready(tie);
      step("memadr", w_memadr);
      for (int i = 0; i < mem_wait; i++) begin
        mem_ready = 1'b0;
        step(op == OP_LW ? "memrd_wait" : "memwr_wait", op == OP_LW ? w_memrd : w_memwr);
      end
      mem_ready = 1'b1;
      if (op == OP_LW) begin
        step("memrd", w_memrd);
        mem_ready = rnd_ready(tie);
        step("memwb", w_memwb);
      end else begin
        step("memwr", w_memwr);
      end
      exp_count = exp_count + 32'd1;
    end else if (op == OP_R) begin
      mem_ready = rnd_ready(tie); step("rtype_ex", w_rtype_ex);
      mem_ready = rnd_ready(tie); step("rtype_wb", w_rtype_wb);
      exp_count = exp_count + 32'd1;
    end else if (op == OP_BEQ) begin
      mem_ready = rnd_ready(tie); step("branch", w_branch);
      exp_count = exp_count + 32'd1;
    end else if (op == OP_J) begin
      mem_ready = rnd_ready(tie); step("jump", w_jump);
      exp_count = exp_count + 32'd1;
    end else if (op == OP_ADDI && ADDI_EN) begin
      mem_ready = rnd_ready(tie); step("addi_ex", w_addi_ex);
      mem_ready = rnd_ready(tie); step("addi_wb", w_addi_wb);
      exp_count = exp_count + 32'd1;
    end else begin
      exp_ill = 1'b1;
    end
  endtask

  logic [5:0] pick;

  initial begin
    exp_count = '0;
    exp_ill   = 1'b0;
    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b1;

    // reset state
    @(posedge clk); #1;
    check("state_known", 32'($isunknown(state)), 32'd0);
    step("reset_idle", w_idle);
    rst_n = 1'b1;
    step("idle", w_idle);

    // R-type with mem_ready tied high: RTYPE_WB lands in cycle 5 after release
    run_instr(OP_R, 0, 0, 1'b1);
    mem_ready = 1'b1;
    step("rtype_next_fetch", w_fetch);
    check("rtype_count", instr_count, 32'd1);

    // lw with three wait cycles in MEMRD
    exp_count = instr_count == 32'd1 ? 32'd1 : exp_count;
    opcode = OP_LW; mem_ready = 1'b1;
    step("lw_decode", w_decode);
    mem_ready = 1'b0; step("lw_memadr", w_memadr);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0; step("lw_memrd_hold", w_memrd);
    end
    mem_ready = 1'b1; step("lw_memrd", w_memrd);
    mem_ready = 1'b0; step("lw_memwb", w_memwb);
    exp_count = exp_count + 32'd1;

    // illegal opcode
    run_instr(6'b111111, 1, 0, 1'b0);
    mem_ready = 1'b1; opcode = 6'b111111;
    step("after_illegal_fetch", w_fetch);

    // addi: full path when enabled, illegal pulse otherwise
    opcode = OP_ADDI; mem_ready = 1'b0;
    step("addi_decode", w_decode);
    if (ADDI_EN) begin
      step("addi_ex", w_addi_ex);
      step("addi_wb", w_addi_wb);
      exp_count = exp_count + 32'd1;
    end else begin
      exp_ill = 1'b1;
    end
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_SW, 2, 1, 1'b0);

    // reset in the middle of a store
    mem_ready = 1'b1; step("rst_fetch", w_fetch);
    opcode = OP_SW; step("rst_decode", w_decode);
    mem_ready = 1'b0; step("rst_memadr", w_memadr);
    step("rst_memwr", w_memwr);
    rst_n = 1'b0; mem_ready = 1'b1;
    step("rst_memwr_last", w_memwr);
    exp_count = '0;
    rst_n = 1'b1; mem_ready = 1'b0;
    step("rst_idle", w_idle);
    run_instr(OP_R, 0, 0, 1'b0);

    // counter wrap on a retiring jump
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr(OP_J, 1, 0, 1'b0);
    mem_ready = 1'b0;
    step("wrap_fetch", w_fetch_wait);
    check("wrap_zero", instr_count, 32'd0);
    mem_ready = 1'b1; opcode = OP_R;
    step("wrap_fetch_go", w_fetch);
    step("wrap_decode", w_decode);
    step("wrap_rtype_ex", w_rtype_ex);
    step("wrap_rtype_wb", w_rtype_wb);
    exp_count = exp_count + 32'd1;

    // random instruction stream
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0:       pick = OP_R;
        1:       pick = OP_LW;
        2:       pick = OP_SW;
        3:       pick = OP_BEQ;
        4:       pick = OP_J;
        5:       pick = OP_ADDI;
        default: pick = 6'($urandom);
      endcase
      run_instr(pick, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    mem_ready = 1'b0;
    step("final_fetch", w_fetch_wait);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
